// File: rtl/int_ram_dual_bank.sv
// int_ram_dual_bank: intermediate-message store for the LDPC decoder.
// Two independent single-port banks (index 1 and 2) sharing clk and rst_n.
// Each bank has a registered read port with one cycle of latency.
// Out-of-range writes are dropped and out-of-range reads return zero.
// Memory contents are not cleared by reset.
// Optional feature macro: INT_RAM_WRITE_THROUGH_EN.
//   Defined:   a write cycle also loads the written data into data_out.
//   Undefined: data_out holds its previous value during writes.
module int_ram_dual_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in  [2:1],
  input  logic [ADDR_WIDTH-1:0] address  [2:1],
  input  logic                  chip_sel [2:1],
  input  logic                  write_en [2:1],
  output logic [DATA_WIDTH-1:0] data_out [2:1]
);

  // One array per bank; the banks never interact.
  logic [DATA_WIDTH-1:0] mem [2:1][RAM_DEPTH];

  // Range check. A zero bit is prepended to the address so the compare
  // cannot overflow when RAM_DEPTH equals 2**ADDR_WIDTH.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < RAM_DEPTH[ADDR_WIDTH:0]);
  endfunction

  // Per-bank access. Reset clears only the read registers and blocks writes;
  // the memory array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 1; b <= 2; b++) begin
        data_out[b] <= '0;
      end
    end else begin
      for (int b = 1; b <= 2; b++) begin
        if (chip_sel[b]) begin
          if (write_en[b]) begin
            if (addr_in_range(address[b])) begin
              mem[b][address[b]] <= data_in[b];
            end
`ifdef INT_RAM_WRITE_THROUGH_EN
            data_out[b] <= data_in[b];
`endif
          end else begin
            if (addr_in_range(address[b])) begin
              data_out[b] <= mem[b][address[b]];
            end else begin
              data_out[b] <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_int_ram_dual_bank.sv
// Directed self-checking bench for int_ram_dual_bank.
module tb_int_ram_dual_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in  [2:1];
  logic [7:0] address  [2:1];
  logic       chip_sel [2:1];
  logic       write_en [2:1];
  logic [7:0] data_out [2:1];

  int checks;
  int failures;

  int_ram_dual_bank #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .address  (address),
    .chip_sel (chip_sel),
    .write_en (write_en),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int b, input logic cs, input logic we,
                       input logic [7:0] addr, input logic [7:0] din);
    chip_sel[b] = cs;
    write_en[b] = we;
    address[b]  = addr;
    data_in[b]  = din;
  endtask

  task automatic chk(input string name, input int b, input logic [7:0] exp);
    checks++;
    if (data_out[b] !== exp) begin
      failures++;
      $display("FAIL %s bank%0d: got %h expected %h", name, b, data_out[b], exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b1, 1'b0, 8'd0, 8'd0);
    step(); step(); step();
    chk("reset_hold", 1, 8'd0);
    chk("reset_hold", 2, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dual_write_read();
    drive(1, 1'b1, 1'b1, 8'd0, 8'd76);
    drive(2, 1'b1, 1'b1, 8'd0, 8'd45);
    step();
`ifdef INT_RAM_WRITE_THROUGH_EN
    chk("write_out", 1, 8'd76);
    chk("write_out", 2, 8'd45);
`else
    chk("write_hold", 1, 8'd0);
    chk("write_hold", 2, 8'd0);
`endif
    drive(1, 1'b1, 1'b1, 8'd1, 8'd44);
    drive(2, 1'b1, 1'b1, 8'd1, 8'd35);
    step();
    drive(1, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b1, 1'b0, 8'd0, 8'd0);
    step();
    chk("read_addr0", 1, 8'd76);
    chk("read_addr0", 2, 8'd45);
  endtask

  task automatic test_diff_addr();
    drive(1, 1'b1, 1'b0, 8'd1, 8'd0);
    drive(2, 1'b1, 1'b0, 8'd0, 8'd0);
    step();
    chk("swap_addr", 1, 8'd44);
    chk("swap_addr", 2, 8'd45);
    drive(1, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b1, 1'b0, 8'd1, 8'd0);
    step();
    chk("diff_addr", 1, 8'd76);
    chk("diff_addr", 2, 8'd35);
  endtask

  task automatic test_cs_hold();
    drive(1, 1'b1, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b0, 1'b0, 8'd0, 8'd0);
    step();
    chk("cs_read", 1, 8'd76);
    chk("cs_hold", 2, 8'd35);
    drive(2, 1'b0, 1'b1, 8'd1, 8'd99);
    step();
    chk("cs_hold_we", 2, 8'd35);
    drive(2, 1'b1, 1'b0, 8'd1, 8'd0);
    step();
    chk("cs_nowrite", 2, 8'd35);
  endtask

  task automatic test_mixed();
    drive(1, 1'b1, 1'b1, 8'd0, 8'd78);
    drive(2, 1'b1, 1'b0, 8'd1, 8'd0);
    step();
    chk("mixed_read", 2, 8'd35);
`ifdef INT_RAM_WRITE_THROUGH_EN
    chk("mixed_wt", 1, 8'd78);
`else
    chk("mixed_hold", 1, 8'd76);
`endif
    drive(1, 1'b1, 1'b0, 8'd0, 8'd0);
    step();
    chk("mixed_rb", 1, 8'd78);
  endtask

  task automatic test_back_to_back();
    drive(1, 1'b1, 1'b1, 8'd3, 8'hA5);
    drive(2, 1'b1, 1'b1, 8'd3, 8'h3C);
    step();
    drive(1, 1'b1, 1'b0, 8'd3, 8'h00);
    drive(2, 1'b1, 1'b0, 8'd3, 8'h00);
    step();
    chk("raw", 1, 8'hA5);
    chk("raw", 2, 8'h3C);
  endtask

  task automatic test_boundary();
    drive(1, 1'b1, 1'b1, 8'd255, 8'h5A);
    drive(2, 1'b0, 1'b0, 8'd0, 8'h00);
    step();
    drive(1, 1'b0, 1'b0, 8'd0, 8'h00);
    drive(2, 1'b1, 1'b1, 8'd255, 8'hFF);
    step();
    drive(1, 1'b1, 1'b0, 8'd255, 8'h00);
    drive(2, 1'b1, 1'b0, 8'd255, 8'h00);
    step();
    chk("addr255", 1, 8'h5A);
    chk("addr255", 2, 8'hFF);
  endtask

  task automatic test_reset_midcycle();
    drive(1, 1'b0, 1'b0, 8'd0, 8'h00);
    drive(2, 1'b0, 1'b0, 8'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 1, 8'd0);
    chk("async_rst", 2, 8'd0);
    drive(1, 1'b1, 1'b1, 8'd255, 8'h99);
    drive(2, 1'b1, 1'b1, 8'd255, 8'h99);
    step();
    chk("rst_wr_hold", 1, 8'd0);
    drive(1, 1'b1, 1'b0, 8'd255, 8'h00);
    drive(2, 1'b1, 1'b0, 8'd255, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_read", 1, 8'h5A);
    chk("post_rst_read", 2, 8'hFF);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_dual_write_read();
    test_diff_addr();
    test_cs_hold();
    test_mixed();
    test_back_to_back();
    test_boundary();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
